// File: rtl/uart_io_bridge.sv
// uart_io_bridge: turns core IO requests into UART byte frames (write) or collects received bytes (read).
// Define UART_RX_FIFO_EN for a 16-entry RX FIFO; otherwise RX uses a single-byte holding register.
//
// state    | meaning
// IDLE     | ready; a request is accepted combinationally
// TX_LOAD  | first byte loaded into the frame shifter
// TX_SHIFT | frames shifting out on uart_tx, bytes back-to-back
// RX_WAIT  | popping received bytes into byte lanes
// FINISH   | one-cycle done pulse
module uart_io_bridge #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        order,
  input  logic [1:0]  size,
  input  logic [31:0] o_data,
  input  logic        write_flag,
  output logic        accepted,
  output logic        done,
  output logic [31:0] i_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, TX_LOAD, TX_SHIFT, RX_WAIT, FINISH} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  state_t        state, state_nxt;
  rstate_t       rstate, rstate_nxt;
  logic [1:0]    size_q, byte_idx, byte_nxt;
  logic          wr_q;
  logic [31:0]   data_q, data_nxt, rd_acc, acc_nxt, rd_word;
  logic [CW-1:0] baud, baud_nxt, rcnt, rcnt_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [9:0]    tx_sr, tx_sr_nxt;
  logic [2:0]    rbit, rbit_nxt;
  logic [7:0]    rx_sr, rx_sr_nxt, rx_head;
  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  logic          push, push_ok, pop, rx_avail, rd_last;

  assign accepted = order && (state == IDLE);
  assign done     = (state == FINISH);
  assign uart_tx  = (state == TX_SHIFT) ? tx_sr[0] : 1'b1;
  assign rx_s     = sync[1];
  assign pop      = (state == RX_WAIT) && !wr_q && rx_avail;
  assign rd_word  = rd_acc | ({24'd0, rx_head} << {byte_idx, 3'b000});

  always_comb begin
    state_nxt  = state;
    byte_nxt   = byte_idx;
    data_nxt   = data_q;
    acc_nxt    = rd_acc;
    baud_nxt   = baud;
    bit_nxt    = bit_cnt;
    tx_sr_nxt  = tx_sr;
    rd_last    = 1'b0;
    rstate_nxt = rstate;
    rcnt_nxt   = rcnt;
    rbit_nxt   = rbit;
    rx_sr_nxt  = rx_sr;
    push       = 1'b0;
    case (state)
      IDLE: if (accepted) begin
        byte_nxt  = 2'd0;
        acc_nxt   = 32'd0;
        data_nxt  = o_data;
        state_nxt = write_flag ? TX_LOAD : RX_WAIT;
      end
      TX_LOAD: begin
        tx_sr_nxt = {1'b1, data_q[7:0], 1'b0};
        bit_nxt   = 4'd0;
        baud_nxt  = BIT_LAST;
        state_nxt = TX_SHIFT;
      end
      TX_SHIFT: if (baud != '0) begin
        baud_nxt = baud - CW'(1);
      end else begin
        baud_nxt = BIT_LAST;
        if (bit_cnt == 4'd9) begin
          // Next byte is lined up in data_q[15:8] so its start bit follows with no gap.
          if (byte_idx == size_q) begin
            state_nxt = FINISH;
          end else begin
            byte_nxt  = byte_idx + 2'd1;
            data_nxt  = {8'd0, data_q[31:8]};
            tx_sr_nxt = {1'b1, data_q[15:8], 1'b0};
            bit_nxt   = 4'd0;
          end
        end else begin
          tx_sr_nxt = {1'b1, tx_sr[9:1]};
          bit_nxt   = bit_cnt + 4'd1;
        end
      end
      RX_WAIT: if (pop) begin
        acc_nxt = rd_word;
        if (byte_idx == size_q) begin
          state_nxt = FINISH;
          rd_last   = 1'b1;
        end else begin
          byte_nxt = byte_idx + 2'd1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (rstate)
      R_IDLE: if (rx_prev && !rx_s) begin
        rstate_nxt = R_START;
        rcnt_nxt   = HALF_LAST;
      end
      R_START: if (rcnt != '0) begin
        rcnt_nxt = rcnt - CW'(1);
      end else if (!rx_s) begin
        rstate_nxt = R_DATA;
        rcnt_nxt   = BIT_LAST;
        rbit_nxt   = 3'd0;
      end else begin
        rstate_nxt = R_IDLE;
      end
      R_DATA: if (rcnt != '0) begin
        rcnt_nxt = rcnt - CW'(1);
      end else begin
        rcnt_nxt  = BIT_LAST;
        rx_sr_nxt = {rx_s, rx_sr[7:1]};
        if (rbit == 3'd7) rstate_nxt = R_STOP;
        else              rbit_nxt   = rbit + 3'd1;
      end
      R_STOP: if (rcnt != '0) begin
        rcnt_nxt = rcnt - CW'(1);
      end else begin
        push       = rx_s;
        rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rstate   <= R_IDLE;
      size_q   <= 2'd0;
      wr_q     <= 1'b0;
      byte_idx <= 2'd0;
      data_q   <= 32'd0;
      rd_acc   <= 32'd0;
      baud     <= '0;
      bit_cnt  <= 4'd0;
      tx_sr    <= '1;
      rcnt     <= '0;
      rbit     <= 3'd0;
      rx_sr    <= 8'd0;
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      i_data   <= 32'd0;
    end else begin
      state    <= state_nxt;
      rstate   <= rstate_nxt;
      byte_idx <= byte_nxt;
      data_q   <= data_nxt;
      rd_acc   <= acc_nxt;
      baud     <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_sr    <= tx_sr_nxt;
      rcnt     <= rcnt_nxt;
      rbit     <= rbit_nxt;
      rx_sr    <= rx_sr_nxt;
      sync     <= {sync[0], uart_rx};
      rx_prev  <= rx_s;
      if (accepted) begin
        size_q <= size;
        wr_q   <= write_flag;
      end
      if (rd_last) i_data <= rd_word;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] rx_count;

  assign rx_avail = (rx_count != 5'd0);
  assign rx_head  = mem[rd_ptr];
  assign push_ok  = push && (rx_count != 5'd16);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      rx_count <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 4'd1;
      if (pop)     rd_ptr <= rd_ptr + 4'd1;
      rx_count <= rx_count + {4'd0, push_ok} - {4'd0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_sr;
  end
`else
  logic [7:0] rx_hold;
  logic       rx_valid;

  assign rx_avail = rx_valid;
  assign rx_head  = rx_hold;
  assign push_ok  = push && !rx_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_hold  <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        rx_hold  <= rx_sr;
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed bench for uart_io_bridge at CLK_PER_BIT=4: table of write/read vectors plus corner sequences.
module tb_uart_io_bridge;
  logic        clk = 1'b0;
  logic        rstn, order, write_flag, uart_rx;
  logic [1:0]  size;
  logic [31:0] o_data;
  logic        accepted, done, uart_tx;
  logic [31:0] i_data;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [31:0] last_idata = 32'd0;

  uart_io_bridge #(.CLK_PER_BIT(4)) dut (
    .clk(clk), .rstn(rstn), .order(order), .size(size), .o_data(o_data),
    .write_flag(write_flag), .accepted(accepted), .done(done), .i_data(i_data),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt   <= done_cnt + 1;
      last_idata <= i_data;
    end
  end

  // bytes: for writes the bytes expected on the line (bits [7:0] first);
  // for reads the bytes sent on uart_rx, npre before the request and npost after it.
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] wdata;
    int          npre;
    int          npost;
    logic [31:0] bytes;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rx = bits[j];
      repeat (4) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [31:0] d, input logic [31:0] bexp);
    int n, line_err, acc_err, dones, done_at, bi, bn;
    logic [9:0] fr;
    logic expb;
    n = int'(sz) + 1;
    line_err = 0; acc_err = 0; dones = 0; done_at = -1;
    write_flag = 1'b1; size = sz; o_data = d; order = 1'b1;
    #1 chk("wr_accept", {31'd0, accepted}, 32'd1);
    @(posedge clk); #1;
    order = 1'b0; o_data = 32'hDEAD_BEEF; size = 2'd0; write_flag = 1'b0;
    for (int k = 1; k <= 40 * n + 3; k++) begin
      if (k >= 2 && k <= 40 * n + 1) begin
        bi   = (k - 2) / 40;
        bn   = ((k - 2) % 40) / 4;
        fr   = {1'b1, bexp[8*bi +: 8], 1'b0};
        expb = fr[bn];
      end else begin
        expb = 1'b1;
      end
      if (uart_tx !== expb) line_err++;
      if (done === 1'b1) begin
        dones++;
        done_at = k;
      end
      if (order && accepted) acc_err++;
      if (k == 9) begin
        order = 1'b1; write_flag = 1'b1;
      end
      if (k == 30) order = 1'b0;
      @(posedge clk); #1;
    end
    chk("wr_line_errors", 32'(line_err), 32'd0);
    chk("wr_done_count", 32'(dones), 32'd1);
    chk("wr_done_cycle", 32'(done_at), 32'(40 * n + 2));
    chk("wr_busy_accept", 32'(acc_err), 32'd0);
  endtask

  task automatic do_read(input logic [1:0] sz, input int npre, input int npost,
                         input logic [31:0] bytes, input logic [31:0] exp);
    int d0, t;
    bit timed_out;
    for (int i = 0; i < npre; i++) send_frame(bytes[8*i +: 8], 1'b1);
    d0 = done_cnt;
    write_flag = 1'b0; size = sz; order = 1'b1;
    #1 chk("rd_accept", {31'd0, accepted}, 32'd1);
    @(posedge clk); #1;
    order = 1'b0; size = 2'd0;
    timed_out = 1'b0;
    fork
      for (int i = npre; i < npre + npost; i++) send_frame(bytes[8*i +: 8], 1'b1);
      begin
        t = 0;
        while (done_cnt == d0 && t < 60 * npost + 50) begin
          @(posedge clk);
          t++;
        end
        #1;
        if (done_cnt == d0) timed_out = 1'b1;
      end
    join
    chk("rd_done_count", 32'(done_cnt - d0), 32'd1);
    chk("rd_data", last_idata, exp);
    if (timed_out) do_reset();
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'h0000_00A5, 0, 0, 32'h0000_00A5, 32'h0};
    vecs[1] = '{1'b1, 2'd3, 32'h1234_5678, 0, 0, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 2'd1, 32'hFFFF_C33C, 0, 0, 32'h0000_C33C, 32'h0};
    vecs[3] = '{1'b1, 2'd2, 32'h00A1_B2C3, 0, 0, 32'h00A1_B2C3, 32'h0};
`ifdef UART_RX_FIFO_EN
    vecs[4] = '{1'b0, 2'd1, 32'h0, 2, 0, 32'h0000_BEEF, 32'h0000_BEEF};
`else
    vecs[4] = '{1'b0, 2'd1, 32'h0, 1, 1, 32'h0000_BEEF, 32'h0000_BEEF};
`endif
    vecs[5] = '{1'b0, 2'd1, 32'h0, 0, 2, 32'h0000_BEEF, 32'h0000_BEEF};
    vecs[6] = '{1'b0, 2'd2, 32'h0, 0, 3, 32'h0033_2211, 32'h0033_2211};
    vecs[7] = '{1'b0, 2'd3, 32'h0, 0, 4, 32'hEFBE_ADDE, 32'hEFBE_ADDE};

    rstn = 1'b0; order = 1'b0; write_flag = 1'b0; size = 2'd0; o_data = 32'd0; uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_accepted", {31'd0, accepted}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) do_write(vecs[v].sz, vecs[v].wdata, vecs[v].bytes);
      else do_read(vecs[v].sz, vecs[v].npre, vecs[v].npost, vecs[v].bytes, vecs[v].exp);
    end

    // framing error: bad-stop 0x55 is dropped, good 0x33 follows
    send_frame(8'h55, 1'b0);
    send_frame(8'h33, 1'b1);
    do_read(2'd0, 0, 0, 32'h0, 32'h0000_0033);

    // i_data holds across an unrelated write
    do_write(2'd0, 32'h0000_0081, 32'h0000_0081);
    chk("rd_hold", i_data, 32'h0000_0033);

    // overflow: surplus frames dropped, oldest bytes kept
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
    do_read(2'd3, 0, 0, 32'h0, 32'h0403_0201);
    do_read(2'd3, 0, 0, 32'h0, 32'h0807_0605);
    do_read(2'd3, 0, 0, 32'h0, 32'h0C0B_0A09);
    do_read(2'd3, 0, 0, 32'h0, 32'h100F_0E0D);
`else
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    do_read(2'd0, 0, 0, 32'h0, 32'h0000_0001);
`endif
    do_read(2'd0, 0, 1, 32'h0000_005A, 32'h0000_005A);

    // reset in the middle of a 4-byte all-zero write
    write_flag = 1'b1; size = 2'd3; o_data = 32'd0; order = 1'b1;
    @(posedge clk); #1;
    order = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    chk("rst_mid_line_before", {31'd0, uart_tx}, 32'd0);
    begin
      int d0;
      d0 = done_cnt;
      rstn = 1'b0;
      #1;
      chk("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_i_data", i_data, 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("rst_idle_line", {31'd0, uart_tx}, 32'd1);
    end
    do_write(2'd0, 32'h0000_005A, 32'h0000_005A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
